// File: rtl/grf_dump.sv
// 32 x 32-bit MIPS general register file: two combinational read ports, one
// synchronous write port, plus a debug engine that streams every register out.
module grf_dump #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [AW-1:0] a3,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          dump_req,
    output logic          dump_busy,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_done
);

    localparam int unsigned N = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [DW-1:0] r_regs [N];
    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_byp1;
    logic          w_byp2;

    // Storage; entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '{default: '0};
        end else if (we && (a3 != '0)) begin
            r_regs[a3] <= wd;
        end
    end

    // Forwarding of the in-flight write to a matching read port.
    assign w_byp1 = BYPASS && we && (a3 == a1);
    assign w_byp2 = BYPASS && we && (a3 == a2);

    assign rd1 = (a1 == '0) ? '0 : (w_byp1 ? wd : r_regs[a1]);
    assign rd2 = (a2 == '0) ? '0 : (w_byp2 ? wd : r_regs[a2]);

    // Dump sequencer: status flags are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (dump_req) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (r_cnt == AW'(N - 1)) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Dump data shows pre-edge contents; a same-cycle write appears only later.
    assign dump_busy  = r_busy;
    assign dump_valid = r_valid;
    assign dump_done  = r_done;
    assign dump_idx   = r_valid ? r_cnt : '0;
    assign dump_data  = r_valid ? r_regs[r_cnt] : '0;

endmodule

// File: tb/tb_grf_dump.sv
// Directed bench for grf_dump: reset, r0 handling, write bypass (both BYPASS
// settings), full dump sequencing, mid-scan writes/requests and reset abort.
module tb_grf_dump;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        dump_req;
    logic        dump_busy;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_done;

    logic [31:0] nb_rd1;
    logic [31:0] nb_rd2;
    logic        nb_busy;
    logic        nb_valid;
    logic [4:0]  nb_idx;
    logic [31:0] nb_data;
    logic        nb_done;

    int n_checks = 0;
    int n_errors = 0;

    grf_dump #(.DW(32), .AW(5), .BYPASS(1'b1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .wd         (wd),
        .rd1        (rd1),
        .rd2        (rd2),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    // Non-bypassing copy sharing the same stimulus.
    grf_dump #(.DW(32), .AW(5), .BYPASS(1'b0)) u_dut_nb (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .wd         (wd),
        .rd1        (nb_rd1),
        .rd2        (nb_rd2),
        .dump_req   (dump_req),
        .dump_busy  (nb_busy),
        .dump_valid (nb_valid),
        .dump_idx   (nb_idx),
        .dump_data  (nb_data),
        .dump_done  (nb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1;
        a3 = addr;
        wd = data;
        tick();
        we = 1'b0;
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, "_busy"},  32'(dump_busy),  32'd0);
        check({tag, "_valid"}, 32'(dump_valid), 32'd0);
        check({tag, "_done"},  32'(dump_done),  32'd0);
        check({tag, "_idx"},   32'(dump_idx),   32'd0);
        check({tag, "_data"},  dump_data,       32'd0);
    endtask

    function automatic logic [31:0] pre(input int k);
        return 32'(k) * 32'h0000_0101;
    endfunction

    initial begin
        logic [31:0] exp;
        reset    = 1'b0;
        we       = 1'b0;
        a1       = '0;
        a2       = '0;
        a3       = '0;
        wd       = '0;
        dump_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_dump_idle("por");
        a1 = 5'd7;
        a2 = 5'd31;
        #1;
        check("por_rd1", rd1, 32'd0);
        check("por_rd2", rd2, 32'd0);

        // Writes to r0 are dropped.
        write_reg(5'd0, 32'hDEAD_BEEF);
        a1 = 5'd0;
        a2 = 5'd0;
        #1;
        check("r0_rd1", rd1, 32'd0);
        check("r0_rd2", rd2, 32'd0);

        // Same-cycle read of the register being written.
        we = 1'b1;
        a3 = 5'd5;
        wd = 32'h1234_5678;
        a1 = 5'd5;
        a2 = 5'd5;
        #1;
        check("byp_rd1",    rd1,    32'h1234_5678);
        check("byp_rd2",    rd2,    32'h1234_5678);
        check("nobyp_rd1",  nb_rd1, 32'd0);
        tick();
        we = 1'b0;
        #1;
        check("post_rd1",   rd1,    32'h1234_5678);
        check("nobyp_post", nb_rd1, 32'h1234_5678);

        // Asynchronous reset clears written contents.
        write_reg(5'd9, 32'hCAFE_0009);
        a1 = 5'd9;
        #1;
        check("pre_rst_rd1", rd1, 32'hCAFE_0009);
        reset = 1'b0;
        #1;
        check("rst_rd1", rd1, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        check_dump_idle("rst");
        #2;
        reset = 1'b1;
        tick();
        check("rst_rel_rd1", rd1, 32'd0);

        // Preload reg[k] = k*0x0101.
        for (int k = 1; k < 32; k++) write_reg(5'(k), pre(k));
        a1 = 5'd31;
        a2 = 5'd16;
        #1;
        check("pre_rd31", rd1, 32'h0000_1F1F);
        check("pre_rd16", rd2, 32'h0000_1010);

        // Full dump.
        dump_req = 1'b1;
        #1;
        check("req_pre_valid", 32'(dump_valid), 32'd0);
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("d1_valid", 32'(dump_valid), 32'd1);
            check("d1_busy",  32'(dump_busy),  32'd1);
            check("d1_idx",   32'(dump_idx),   32'(i));
            check("d1_data",  dump_data,       pre(i));
            check("d1_done",  32'(dump_done),  32'd0);
            tick();
        end
        check("d1_done_p",  32'(dump_done),  32'd1);
        check("d1_done_v",  32'(dump_valid), 32'd0);
        check("d1_done_b",  32'(dump_busy),  32'd1);
        check("d1_done_id", 32'(dump_idx),   32'd0);
        tick();
        check_dump_idle("d1_end");

        // Second dump: mid-scan write to reg 10 and a stray request.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                we = 1'b1;
                a3 = 5'd10;
                wd = 32'd1;
                #1;
            end else if (i == 11) begin
                we = 1'b0;
                a1 = 5'd10;
                #1;
                check("d2_rd10", rd1, 32'd1);
            end
            dump_req = (i == 12);
            exp = (i == 10) ? pre(10) : pre(i);
            check("d2_valid", 32'(dump_valid), 32'd1);
            check("d2_idx",   32'(dump_idx),   32'(i));
            check("d2_data",  dump_data,       exp);
            tick();
        end
        dump_req = 1'b0;
        check("d2_done_p", 32'(dump_done), 32'd1);
        tick();
        check_dump_idle("d2_end");
        tick();
        check_dump_idle("d2_quiet");

        // Third dump aborted by reset at idx 17.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("d3_idx17",  32'(dump_idx), 32'd17);
        check("d3_data17", dump_data,     pre(17));
        reset = 1'b0;
        #1;
        check_dump_idle("d3_abort");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d3_quiet_valid", 32'(dump_valid), 32'd0);
            check("d3_quiet_busy",  32'(dump_busy),  32'd0);
        end

        // Fresh dump after reset reads cleared contents.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("d4_idx3",  32'(dump_idx), 32'd3);
        check("d4_data3", dump_data,     32'd0);
        check("d4_nb_idx", 32'(nb_idx),  32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
